seg_scan_to_bcd: RTL and testbench

//  Decodes a multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) back into BCD digits.
//  - Filters strobe glitches with a stability counter and assembles a full frame of NUM_DIGITS digits.
//  - Delivers each frame through a valid/ack handshake.
//  - Sits on the display side of the BCD-to-segment path; used for self-check and loopback of the display driver.

---
 rtl/seg_scan_to_bcd.sv | 116 +++++++++++
 tb/tb_seg_scan_to_bcd.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_to_bcd.sv
// seg_scan_to_bcd: decodes a multiplexed 7-segment scan bus back into a BCD frame with valid/ack handshake
// Ports:
//   i_clk, i_reset      rising-edge clock, synchronous active-high reset
//   i_segInput[6:0]     segment lines of the currently strobed digit
//   i_digitSel[N-1:0]   one-hot active-high digit strobe
//   i_frameAck          consumer accepts the frame on o_bcdOutput
//   o_bcdOutput[4N-1:0] delivered frame, digit d in bits [4d+3:4d]
//   o_frameValid        frame valid, held until acked
//   o_error             1-cycle pulse on capture of an undecodable pattern
//   o_overrun           1-cycle pulse when a completed frame is dropped
// Optional feature: define SEG_BLANK_EN to decode the all-zero pattern as blank code 4'hA.
module seg_scan_to_bcd #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [6:0]              i_segInput,
    input  logic [NUM_DIGITS-1:0]   i_digitSel,
    input  logic                    i_frameAck,
    output logic [4*NUM_DIGITS-1:0] o_bcdOutput,
    output logic                    o_frameValid,
    output logic                    o_error,
    output logic                    o_overrun
);
    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    err_q, err_d;
    logic                    ovr_q, ovr_d;
    logic                    same, onehot, capture, full, load;
    logic [4:0]              dec;

    // Returns {undecodable, bcd}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1110111: decode = 5'h00;
            7'b0100100: decode = 5'h01;
            7'b0011111: decode = 5'h02;
            7'b0111110: decode = 5'h03;
            7'b1101100: decode = 5'h04;
            7'b1111010: decode = 5'h05;
            7'b1111011: decode = 5'h06;
            7'b0110100: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1111110: decode = 5'h09;
`ifdef SEG_BLANK_EN
            7'b0000000: decode = 5'h0A;
`endif
            default:    decode = 5'h1F;
        endcase
    endfunction

    always_comb begin
        seg_d    = i_segInput;
        sel_d    = i_digitSel;
        same     = {seg_d, sel_d} == {seg_q, sel_q};
        onehot   = (sel_d != '0) && ((sel_d & (sel_d - 1'b1)) == '0);
        cnt_d    = !onehot ? '0 : !same ? CNT_W'(1) :
                   (cnt_q == CNT_W'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
        // done_q marks that the current stable window already captured, so a long hold captures only once
        capture  = (cnt_q == CNT_W'(STABLE_CYCLES)) && !done_q;
        done_d   = onehot && same && (done_q || capture);
        dec      = decode(seg_q);
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (capture && sel_q[i]) shadow_d[4*i +: 4] = dec[3:0];
        full     = &mask_q;
        // a capture on the completion edge starts the next frame in the cleared mask
        mask_d   = (full ? '0 : mask_q) | (capture ? sel_q : '0);
        load     = full && (state_q == COLLECT || i_frameAck);
        bcd_d    = load ? shadow_q : bcd_q;
        ovr_d    = full && !load;
        err_d    = capture && dec[4];
        state_d  = load ? HOLD : i_frameAck ? COLLECT : state_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= COLLECT;
            seg_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            shadow_q <= '0;
            bcd_q    <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            bcd_q    <= bcd_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign o_bcdOutput  = bcd_q;
    assign o_frameValid = state_q == HOLD;
    assign o_error      = err_q;
    assign o_overrun    = ovr_q;
endmodule

// File: tb/tb_seg_scan_to_bcd.sv
// tb_seg_scan_to_bcd: randomized and directed bench for seg_scan_to_bcd against a frame-level reference model
module tb_seg_scan_to_bcd;
    localparam int N = 4;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [6:0]     seg;
    logic [N-1:0]   sel;
    logic           ack;
    logic [4*N-1:0] bcd;
    logic           valid, err, ovr;

    seg_scan_to_bcd #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .CNT_W(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_segInput(seg), .i_digitSel(sel), .i_frameAck(ack),
        .o_bcdOutput(bcd), .o_frameValid(valid), .o_error(err), .o_overrun(ovr)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [10] = '{7'b1110111, 7'b0100100, 7'b0011111, 7'b0111110, 7'b1101100,
                             7'b1111010, 7'b1111011, 7'b0110100, 7'b1111111, 7'b1111110};

    int n_chk = 0, n_fail = 0;
    int err_seen = 0, ovr_seen = 0;

    // reference model state: run length of the last registered sample, captured digit set, frames
    int           run;
    logic [6:0]   p_seg;
    logic [N-1:0] p_sel;
    bit           got [N];
    int           shadow [N];
    int           frame [N];
    bit           m_valid, m_err, m_ovr;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
        end
    endtask

    function automatic int seg2bcd(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (pat[i] == s) return i;
`ifdef SEG_BLANK_EN
        if (s == 7'd0) return 10;
`endif
        return 15;
    endfunction

    function automatic logic [4*N-1:0] pack();
        logic [4*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(frame[i]);
        return r;
    endfunction

    task automatic model_edge();
        if (rst) begin
            run = 0; p_seg = '0; p_sel = '0;
            m_valid = 0; m_err = 0; m_ovr = 0;
            for (int i = 0; i < N; i++) begin got[i] = 0; shadow[i] = 0; frame[i] = 0; end
        end else begin
            bit cap, full;
            int d, v;
            cap = run == S;
            d = 0;
            for (int i = 0; i < N; i++) if (p_sel[i]) d = i;
            v = seg2bcd(p_seg);
            full = 1;
            for (int i = 0; i < N; i++) full &= got[i];
            m_err = cap && v == 15;
            m_ovr = full && m_valid && !ack;
            if (full && !m_ovr) begin
                for (int i = 0; i < N; i++) frame[i] = shadow[i];
                m_valid = 1;
            end else if (ack) m_valid = 0;
            if (full) for (int i = 0; i < N; i++) got[i] = 0;
            if (cap) begin got[d] = 1; shadow[d] = v; end
            run = ($countones(sel) == 1) ? ((seg == p_seg && sel == p_sel) ? run + 1 : 1) : 0;
            p_seg = seg; p_sel = sel;
        end
    endtask

    task automatic cyc(input logic r, input logic [6:0] s, input logic [N-1:0] d, input logic a);
        rst = r; seg = s; sel = d; ack = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("valid", valid, m_valid);
        check("error", err, m_err);
        check("overrun", ovr, m_ovr);
        check("bcd", bcd, pack());
        err_seen += int'(err);
        ovr_seen += int'(ovr);
    endtask

    task automatic digit(input int idx, input logic [6:0] p, input int len, input int ack_at);
        logic [N-1:0] one;
        one = N'(1) << idx;
        for (int c = 1; c <= len; c++) cyc(1'b0, p, one, c == ack_at);
    endtask

    task automatic frm(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                       input logic [6:0] p3, input int ack_at);
        digit(0, p0, S + 3, 0);
        digit(1, p1, S + 3, 0);
        digit(2, p2, S + 3, 0);
        digit(3, p3, S + 3, ack_at);
    endtask

    initial begin
        int e0, o0;
        // reset with random inputs
        cyc(1'b1, 7'($urandom), N'($urandom), 1'b1);
        cyc(1'b1, 7'($urandom), N'($urandom), 1'b1);
        check("rst_bcd", bcd, 0);
        check("rst_valid", valid, 0);
        check("rst_flags", {err, ovr}, 0);

        // basic frame 3,0,7,9
        frm(pat[3], pat[0], pat[7], pat[9], 0);
        check("frame_bcd", bcd, 16'h9703);
        check("frame_valid", valid, 1);
        cyc(1'b0, 7'd0, '0, 1'b0);
        check("frame_hold", valid, 1);
        cyc(1'b0, 7'd0, '0, 1'b1);
        check("ack_clear", valid, 0);

        // glitch: short strobe then non-one-hot strobe
        e0 = err_seen;
        digit(0, pat[0], 2, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, pat[0], 4'b0011, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 7'd0, '0, 1'b0);
        check("glitch_valid", valid, 0);
        check("glitch_err", err_seen - e0, 0);

        // undecodable pattern on digit 2
        e0 = err_seen;
        frm(pat[1], pat[2], 7'b0000001, pat[4], 0);
        check("inv_err", err_seen - e0, 1);
        check("inv_slot", bcd[11:8], 4'hF);
        check("inv_bcd", bcd, 16'h4F21);
        cyc(1'b0, 7'd0, '0, 1'b1);

        // overrun: second frame dropped, first retained
        o0 = ovr_seen;
        frm(pat[1], pat[2], pat[3], pat[4], 0);
        check("ovr_first", bcd, 16'h4321);
        frm(pat[5], pat[6], pat[7], pat[8], 0);
        check("ovr_pulse", ovr_seen - o0, 1);
        check("ovr_keep", bcd, 16'h4321);
        check("ovr_valid", valid, 1);
        // ack on the completion edge loads the new frame without overrun
        frm(pat[9], pat[8], pat[7], pat[6], S + 2);
        check("ackload_bcd", bcd, 16'h6789);
        check("ackload_valid", valid, 1);
        check("ackload_ovr", ovr_seen - o0, 1);
        cyc(1'b0, 7'd0, '0, 1'b1);

        // all-zero segment pattern
        e0 = err_seen;
        frm(pat[0], 7'd0, pat[2], pat[3], 0);
`ifdef SEG_BLANK_EN
        check("blank_slot", bcd[7:4], 4'hA);
        check("blank_err", err_seen - e0, 0);
`else
        check("blank_slot", bcd[7:4], 4'hF);
        check("blank_err", err_seen - e0, 1);
`endif
        cyc(1'b0, 7'd0, '0, 1'b1);

        // reset mid-frame discards the partial mask
        digit(0, pat[5], S + 3, 0);
        digit(1, pat[6], S + 3, 0);
        cyc(1'b1, 7'($urandom), N'($urandom), 1'($urandom));
        cyc(1'b1, 7'($urandom), N'($urandom), 1'($urandom));
        check("midrst_bcd", bcd, 0);
        digit(2, pat[7], S + 3, 0);
        digit(3, pat[8], S + 3, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 7'd0, '0, 1'b0);
        check("midrst_valid", valid, 0);

        // randomized scan traffic
        for (int k = 0; k < 400; k++) begin
            int idx, len, kind;
            logic [6:0]   p;
            logic [N-1:0] s;
            idx  = int'($urandom_range(0, N - 1));
            kind = int'($urandom_range(0, 19));
            p = kind < 16 ? pat[$urandom_range(0, 9)] : kind < 18 ? 7'($urandom) : 7'd0;
            s = $urandom_range(0, 9) == 0 ? N'($urandom) : N'(1) << idx;
            len = int'($urandom_range(1, S + 3));
            for (int c = 0; c < len; c++)
                cyc($urandom_range(0, 299) == 0, p, s, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
